run_control_fsm: RTL and testbench
==================================

RUN_CONTROL_FSM -- requirements
Module: run_control_fsm

Interface
REQ-001 SHALL have parameter N_BTN, default 5, number of push-button inputs (min 5; bits above 4 ignored).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable samples before a debounced level changes.
REQ-003 SHALL have parameter STEP_N, default 16, clk-enable cycles issued per burst step.
REQ-004 SHALL have parameter RST_CYCLES, default 4, cycles cpu_rst is held for a reset request.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port button, input, N_BTN, raw asynchronous buttons: [0] up=RUN, [1] left=BURST, [2] right=STEP, [3] down=STOP, [4] center=RESET.
REQ-008 SHALL have port bp_hit, input, 1, breakpoint match from datapath (used only under RUN_CTRL_BREAKPOINT_EN).
REQ-009 SHALL have port cpu_en, output, 1, clock enable to the MIC-1 core.
REQ-010 SHALL have port cpu_rst, output, 1, synchronous reset to the MIC-1 core.
REQ-011 SHALL have port led, output, 6, status LEDs.
REQ-012 SHALL have port state, output, 3, current state encoding (state_e).

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser, then a debouncer, then a rising-edge detector yielding a one-cycle press pulse.
REQ-014 SHALL change a debounced level only after DEBOUNCE_CYCLES consecutive identical synchronised samples; a glitch shorter than that produces no pulse.
REQ-015 SHALL implement states IDLE, RUN, STOP, STEP, RSTG; transitions taken on the cycle after the press pulse.
REQ-016 SHALL resolve simultaneous press pulses by priority RESET > STOP > RUN > STEP > BURST; lower-priority pulses in that cycle are discarded.
REQ-017 SHALL on RESET from any state enter RSTG, assert cpu_rst for exactly RST_CYCLES cycles with cpu_en=0, then enter IDLE.
REQ-018 SHALL ignore all other presses while in RSTG.
REQ-019 SHALL on RUN from IDLE or STOP enter RUN; cpu_en=1 every cycle in RUN.
REQ-020 SHALL on STOP from RUN or STEP enter STOP, cpu_en=0 from the next cycle; any remaining step count is cleared.
REQ-021 SHALL on STEP from IDLE or STOP load count 1, on BURST load count STEP_N, and enter STEP; cpu_en=1 for exactly that many cycles, then enter STOP.
REQ-022 SHALL ignore RUN, STEP and BURST presses while in RUN or STEP.
REQ-023 SHALL drive led[0]=RUN, led[1]=STOP, led[2]=STEP, led[3]=RSTG, led[4]=IDLE, led[5]=breakpoint sticky flag.
REQ-024 SHALL register cpu_en, cpu_rst, led and state (no combinational path from button to outputs).
REQ-025 SHALL size the step counter as $clog2(STEP_N+1) bits; no wrap-around possible.

Reset
REQ-026 SHALL on reset: state=IDLE, cpu_en=0, cpu_rst=0, led=6'b010000, step count 0, sticky flag 0, debouncer levels 0, edge detectors primed so a held button yields no pulse after reset.
REQ-027 SHALL let reset override any in-progress STEP or RSTG on the same cycle.

Configuration
REQ-028 SHALL with RUN_CTRL_BREAKPOINT_EN defined: bp_hit=1 in RUN or STEP forces STOP next cycle (cpu_en=0), sets led[5]; led[5] clears on RUN/STEP/BURST/RESET press.
REQ-029 SHALL without RUN_CTRL_BREAKPOINT_EN: bp_hit ignored, led[5] constant 0.

Structure
REQ-030 SHALL place state_e enum, button index constants and LED bit constants in package run_control_pkg.
REQ-031 SHALL instantiate sub-module btn_debounce (synchroniser+debouncer+edge pulse, parameter DEBOUNCE_CYCLES) once per button via generate.

Verification (DEBOUNCE_CYCLES=4, STEP_N=3, RST_CYCLES=2)
REQ-032 SHALL test: reset then hold up 10 cycles -> state RUN, cpu_en=1, led=6'b000001.
REQ-033 SHALL test: in STOP press left -> cpu_en=1 for exactly 3 cycles, then STOP, led=6'b000010.
REQ-034 SHALL test: 3-cycle glitch on right in IDLE -> no transition, cpu_en stays 0.
REQ-035 SHALL test: in RUN press center and down same cycle -> RSTG, cpu_rst=1 for 2 cycles, then IDLE, led=6'b010000.
REQ-036 SHALL test (macro on): in RUN pulse bp_hit -> STOP next cycle, led=6'b100010; press up -> RUN, led[5]=0.
REQ-037 SHALL test: reset asserted mid-STEP -> IDLE next cycle, cpu_en=0, count 0.

Source files
------------

// File: rtl/run_control_pkg.sv
// Shared types and constants for the MIC-1 run-control front panel.
// States, button indices and LED bit positions.
package run_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STOP = 3'd2,
        ST_STEP = 3'd3,
        ST_RSTG = 3'd4
    } state_e;

    localparam int BTN_RUN   = 0;
    localparam int BTN_BURST = 1;
    localparam int BTN_STEP  = 2;
    localparam int BTN_STOP  = 3;
    localparam int BTN_RESET = 4;

    localparam int LED_RUN  = 0;
    localparam int LED_STOP = 1;
    localparam int LED_STEP = 2;
    localparam int LED_RSTG = 3;
    localparam int LED_IDLE = 4;
    localparam int LED_BP   = 5;

    function automatic logic [4:0] state_leds(state_e s);
        logic [4:0] l;
        l = '0;
        case (s)
            ST_RUN:  l[LED_RUN]  = 1'b1;
            ST_STOP: l[LED_STOP] = 1'b1;
            ST_STEP: l[LED_STEP] = 1'b1;
            ST_RSTG: l[LED_RSTG] = 1'b1;
            ST_IDLE: l[LED_IDLE] = 1'b1;
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-count debouncer, rising-edge pulse.
// Level and edge history reset to 0 so reset itself never yields a pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_prev;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_prev <= r_level;
            // Any sample agreeing with the current level restarts the run.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_level & ~r_prev;

endmodule

// File: rtl/run_control_fsm.sv
// Front-panel run control for the MIC-1 core: run/stop/step/burst/reset.
// Define RUN_CTRL_BREAKPOINT_EN to let bp_hit halt the core.
module run_control_fsm
    import run_control_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_N          = 16,
    parameter int RST_CYCLES      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] button,
    input  logic             bp_hit,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [5:0]       led,
    output logic [2:0]       state
);

    localparam int SW = $clog2(STEP_N + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    logic [N_BTN-1:0] w_pulse;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (button[g]),
            .o_pulse(w_pulse[g])
        );
    end

    logic w_p_rst, w_p_stop, w_p_run, w_p_step, w_p_burst;

    // One winner per cycle: RESET > STOP > RUN > STEP > BURST.
    assign w_p_rst   = w_pulse[BTN_RESET];
    assign w_p_stop  = w_pulse[BTN_STOP] & ~w_p_rst;
    assign w_p_run   = w_pulse[BTN_RUN] & ~w_p_rst & ~w_pulse[BTN_STOP];
    assign w_p_step  = w_pulse[BTN_STEP] & ~w_p_rst & ~w_pulse[BTN_STOP]
                     & ~w_pulse[BTN_RUN];
    assign w_p_burst = w_pulse[BTN_BURST] & ~w_p_rst & ~w_pulse[BTN_STOP]
                     & ~w_pulse[BTN_RUN] & ~w_pulse[BTN_STEP];

    state_e        r_state;
    logic [SW-1:0] r_scnt;
    logic [RW-1:0] r_rcnt;
    logic          r_bp;
    logic          r_cpu_en;
    logic          r_cpu_rst;
    logic [5:0]    r_led;

    logic w_active;
    logic w_bp_ev;
    logic w_bp_next;

    assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP);

`ifdef RUN_CTRL_BREAKPOINT_EN
    assign w_bp_ev = bp_hit & w_active;

    always_comb begin
        w_bp_next = r_bp;
        if (w_bp_ev && !w_p_rst) begin
            w_bp_next = 1'b1;
        end else if (w_p_run || w_p_step || w_p_burst || w_p_rst) begin
            w_bp_next = 1'b0;
        end
    end
`else
    assign w_bp_ev   = 1'b0;
    assign w_bp_next = 1'b0;
`endif

    state_e        w_next;
    logic [SW-1:0] w_scnt;
    logic [RW-1:0] w_rcnt;

    always_comb begin
        w_next = r_state;
        w_scnt = r_scnt;
        w_rcnt = r_rcnt;
        if (r_state == ST_RSTG) begin
            if (r_rcnt <= RW'(1)) begin
                w_next = ST_IDLE;
                w_rcnt = '0;
            end else begin
                w_rcnt = r_rcnt - 1'b1;
            end
        end else if (w_p_rst) begin
            w_next = ST_RSTG;
            w_rcnt = RW'(RST_CYCLES);
            w_scnt = '0;
        end else if (w_active && (w_p_stop || w_bp_ev)) begin
            w_next = ST_STOP;
            w_scnt = '0;
        end else if (r_state == ST_IDLE || r_state == ST_STOP) begin
            if (w_p_run) begin
                w_next = ST_RUN;
            end else if (w_p_step) begin
                w_next = ST_STEP;
                w_scnt = SW'(1);
            end else if (w_p_burst) begin
                w_next = ST_STEP;
                w_scnt = SW'(STEP_N);
            end
        end else if (r_state == ST_STEP) begin
            if (r_scnt <= SW'(1)) begin
                w_next = ST_STOP;
                w_scnt = '0;
            end else begin
                w_scnt = r_scnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_scnt    <= '0;
            r_rcnt    <= '0;
            r_bp      <= 1'b0;
            r_cpu_en  <= 1'b0;
            r_cpu_rst <= 1'b0;
            r_led     <= 6'b010000;
        end else begin
            r_state   <= w_next;
            r_scnt    <= w_scnt;
            r_rcnt    <= w_rcnt;
            r_bp      <= w_bp_next;
            r_cpu_en  <= (w_next == ST_RUN) || (w_next == ST_STEP);
            r_cpu_rst <= (w_next == ST_RSTG);
            r_led     <= {w_bp_next, state_leds(w_next)};
        end
    end

    assign cpu_en  = r_cpu_en;
    assign cpu_rst = r_cpu_rst;
    assign led     = r_led;
    assign state   = r_state;

endmodule

// File: tb/tb_run_control_fsm.sv
// Directed bench for run_control_fsm with small debounce/step/reset counts.
// Expected results queue up as stimulus is applied and are checked in order.
module tb_run_control_fsm;
    import run_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] button = '0;
    logic       bp_hit = 1'b0;
    logic       cpu_en;
    logic       cpu_rst;
    logic [5:0] led;
    logic [2:0] state;

    run_control_fsm #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(4),
        .STEP_N         (3),
        .RST_CYCLES     (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .bp_hit (bp_hit),
        .cpu_en (cpu_en),
        .cpu_rst(cpu_rst),
        .led    (led),
        .state  (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad = 0;

    localparam logic [4:0] M_RUN   = 5'b00001;
    localparam logic [4:0] M_BURST = 5'b00010;
    localparam logic [4:0] M_STEP  = 5'b00100;
    localparam logic [4:0] M_STOP  = 5'b01000;
    localparam logic [4:0] M_RESET = 5'b10000;

    function automatic logic [31:0] ev(state_e s, logic en, logic rs,
                                       logic [5:0] l);
        return {21'd0, s, en, rs, l};
    endfunction

    function automatic logic [31:0] obs();
        return {21'd0, state, cpu_en, cpu_rst, led};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] e);
        sb_q.push_back('{tag, e});
    endtask

    task automatic check(input logic [31:0] o);
        sb_t t;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h", o);
        end else begin
            t = sb_q.pop_front();
            assert (o === t.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t.tag, o, t.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [4:0] m);
        button = button | m;
        tick(10);
        button = button & ~m;
        tick(10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    int en_cnt;
    int rst_cnt;
    int overlap;

    initial begin
        tick(2);
        expect_val("reset_hold", ev(ST_IDLE, 1'b0, 1'b0, 6'b010000));
        check(obs());
        reset = 1'b0;
        tick(1);
        expect_val("after_reset", ev(ST_IDLE, 1'b0, 1'b0, 6'b010000));
        check(obs());

        button = M_STEP;
        tick(3);
        button = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            expect_val("glitch_idle", ev(ST_IDLE, 1'b0, 1'b0, 6'b010000));
            check(obs());
        end

        button = M_RUN;
        tick(10);
        expect_val("hold_up_run", ev(ST_RUN, 1'b1, 1'b0, 6'b000001));
        check(obs());
        button = '0;
        tick(10);
        expect_val("run_after_release", ev(ST_RUN, 1'b1, 1'b0, 6'b000001));
        check(obs());

        press(M_STEP);
        expect_val("step_ignored_in_run", ev(ST_RUN, 1'b1, 1'b0, 6'b000001));
        check(obs());

        press(M_STOP);
        expect_val("stop_from_run", ev(ST_STOP, 1'b0, 1'b0, 6'b000010));
        check(obs());

        button = M_BURST;
        en_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (cpu_en) en_cnt++;
        end
        expect_val("burst_en_cycles", 32'd3);
        check(en_cnt);
        expect_val("burst_end_stop", ev(ST_STOP, 1'b0, 1'b0, 6'b000010));
        check(obs());
        button = '0;
        tick(10);

        press(M_RUN);
        expect_val("run_from_stop", ev(ST_RUN, 1'b1, 1'b0, 6'b000001));
        check(obs());

`ifdef RUN_CTRL_BREAKPOINT_EN
        bp_hit = 1'b1;
        tick(1);
        bp_hit = 1'b0;
        expect_val("bp_stop", ev(ST_STOP, 1'b0, 1'b0, 6'b100010));
        check(obs());
        press(M_RUN);
        expect_val("bp_clear_run", ev(ST_RUN, 1'b1, 1'b0, 6'b000001));
        check(obs());
`endif

        button = M_RESET | M_STOP;
        rst_cnt = 0;
        overlap = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (cpu_rst) rst_cnt++;
            if (cpu_rst && cpu_en) overlap++;
        end
        expect_val("rstg_cycles", 32'd2);
        check(rst_cnt);
        expect_val("rstg_en_low", 32'd0);
        check(overlap);
        expect_val("rstg_to_idle", ev(ST_IDLE, 1'b0, 1'b0, 6'b010000));
        check(obs());
        button = '0;
        tick(10);

        press(M_STOP);
        expect_val("stop_ignored_idle", ev(ST_IDLE, 1'b0, 1'b0, 6'b010000));
        check(obs());

        button = M_STEP;
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (cpu_en) en_cnt++;
        end
        expect_val("single_step_en", 32'd1);
        check(en_cnt);
        expect_val("single_step_stop", ev(ST_STOP, 1'b0, 1'b0, 6'b000010));
        check(obs());
        button = '0;
        tick(10);

        button = M_BURST;
        tick(8);
        expect_val("mid_step", ev(ST_STEP, 1'b1, 1'b0, 6'b000100));
        check(obs());
        reset = 1'b1;
        button = '0;
        tick(1);
        expect_val("reset_mid_step", ev(ST_IDLE, 1'b0, 1'b0, 6'b010000));
        check(obs());
        reset = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (cpu_en) en_cnt++;
        end
        expect_val("no_leftover_step", 32'd0);
        check(en_cnt);
        expect_val("idle_after_reset", ev(ST_IDLE, 1'b0, 1'b0, 6'b010000));
        check(obs());

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d required=0",
                     sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
